// File: rtl/irq_pkg.sv
// Shared definitions for the machine-mode interrupt controller: CSR map,
// bit positions inside the CSRs, trap cause codes and controller state.
package irq_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ADDR_W    = 12;

    localparam logic [ADDR_W-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [ADDR_W-1:0] CSR_MIE     = 12'h304;
    localparam logic [ADDR_W-1:0] CSR_MTVEC   = 12'h305;
    localparam logic [ADDR_W-1:0] CSR_MEPC    = 12'h341;
    localparam logic [ADDR_W-1:0] CSR_MCAUSE  = 12'h342;
    localparam logic [ADDR_W-1:0] CSR_MIP     = 12'h344;

    localparam int unsigned BIT_MIE  = 3;
    localparam int unsigned BIT_MPIE = 7;
    localparam int unsigned BIT_MTI  = 7;
    localparam int unsigned BIT_MEI  = 11;

    localparam logic [XLEN-1:0] CAUSE_TIMER = 32'h8000_0007;
    localparam logic [XLEN-1:0] CAUSE_EXT   = 32'h8000_000B;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } irq_state_e;

endpackage

// File: rtl/irq_csr_file.sv
// Machine CSR storage with field masking, read mux and the priority between
// software writes, trap commit, mret restore and the timer pending bit.
module irq_csr_file
    import irq_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                csr_we,
    input  logic [ADDR_W-1:0]   csr_addr,
    input  logic [XLEN-1:0]     csr_wdata,
    output logic [XLEN-1:0]     csr_rdata_c,
    input  logic                timer_irq,
    input  logic                ext_irq,
    input  logic                trap_commit,
    input  logic [XLEN-1:0]     trap_cause,
    input  logic [XLEN-1:0]     instr_pc,
    input  logic                mret_commit,
    output logic                status_mie,
    output logic                mtie,
    output logic                meie,
    output logic                mtip,
    output logic                meip,
    output logic [XLEN-3:0]     mtvec_base,
    output logic                mtvec_mode,
    output logic [XLEN-1:0]     mepc
);

    logic            mie_q, mpie_q, mtie_q, meie_q, mtip_q, mtip_d;
    logic [XLEN-3:0] mtvec_base_q, mepc_q;
    logic            mtvec_mode_q;
    logic [XLEN-1:0] mcause_q;
    logic            wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause, wr_mip;
    logic            unused_pc_lsb;

    assign wr_mstatus = csr_we && (csr_addr == CSR_MSTATUS);
    assign wr_mie     = csr_we && (csr_addr == CSR_MIE);
    assign wr_mtvec   = csr_we && (csr_addr == CSR_MTVEC);
    assign wr_mepc    = csr_we && (csr_addr == CSR_MEPC);
    assign wr_mcause  = csr_we && (csr_addr == CSR_MCAUSE);
    assign wr_mip     = csr_we && (csr_addr == CSR_MIP);

    assign unused_pc_lsb = ^instr_pc[1:0];

    // Timer pending: software write, then trap clear, then a fresh pulse wins.
    always_comb begin
        mtip_d = mtip_q;
        if (wr_mip)
            mtip_d = csr_wdata[BIT_MTI];
        if (trap_commit && (trap_cause == CAUSE_TIMER))
            mtip_d = 1'b0;
        if (timer_irq)
            mtip_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mie_q        <= 1'b0;
            mpie_q       <= 1'b0;
            mtie_q       <= 1'b0;
            meie_q       <= 1'b0;
            mtip_q       <= 1'b0;
            mtvec_base_q <= MTVEC_RESET[XLEN-1:2];
            mtvec_mode_q <= MTVEC_RESET[0];
            mepc_q       <= '0;
            mcause_q     <= '0;
        end else begin
            mtip_q <= mtip_d;
            if (trap_commit) begin
                mpie_q <= mie_q;
                mie_q  <= 1'b0;
            end else if (mret_commit) begin
                mie_q  <= mpie_q;
                mpie_q <= 1'b1;
            end else if (wr_mstatus) begin
                mie_q  <= csr_wdata[BIT_MIE];
                mpie_q <= csr_wdata[BIT_MPIE];
            end
            if (wr_mie) begin
                mtie_q <= csr_wdata[BIT_MTI];
                meie_q <= csr_wdata[BIT_MEI];
            end
            if (wr_mtvec) begin
                mtvec_base_q <= csr_wdata[XLEN-1:2];
                mtvec_mode_q <= csr_wdata[0];
            end
            if (trap_commit)
                mepc_q <= instr_pc[XLEN-1:2];
            else if (wr_mepc)
                mepc_q <= csr_wdata[XLEN-1:2];
            if (trap_commit)
                mcause_q <= trap_cause;
            else if (wr_mcause)
                mcause_q <= csr_wdata;
        end
    end

    always_comb begin
        csr_rdata_c = '0;
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_rdata_c[BIT_MIE]  = mie_q;
                csr_rdata_c[BIT_MPIE] = mpie_q;
            end
            CSR_MIE: begin
                csr_rdata_c[BIT_MTI] = mtie_q;
                csr_rdata_c[BIT_MEI] = meie_q;
            end
            CSR_MTVEC:  csr_rdata_c = {mtvec_base_q, 1'b0, mtvec_mode_q};
            CSR_MEPC:   csr_rdata_c = {mepc_q, 2'b00};
            CSR_MCAUSE: csr_rdata_c = mcause_q;
            CSR_MIP: begin
                csr_rdata_c[BIT_MTI] = mtip_q;
                csr_rdata_c[BIT_MEI] = ext_irq;
            end
            default:    csr_rdata_c = '0;
        endcase
    end

    assign status_mie = mie_q;
    assign mtie       = mtie_q;
    assign meie       = meie_q;
    assign mtip       = mtip_q;
    assign meip       = ext_irq;
    assign mtvec_base = mtvec_base_q;
    assign mtvec_mode = mtvec_mode_q;
    assign mepc       = {mepc_q, 2'b00};

endmodule

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: arbitrates pending interrupts into a
// held trap request, commits the trap on acknowledge and services mret.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              timer_irq,
    input  logic              ext_irq,
    input  logic              csr_we,
    input  logic [11:0]       csr_addr,
    input  logic [31:0]       csr_wdata,
    output logic [31:0]       csr_rdata,
    input  logic [31:0]       instr_pc,
    input  logic              is_mret,
    output logic              trap_req,
    input  logic              trap_ack,
    output logic              redirect,
    output logic [31:0]       trap_pc
);

    irq_state_e      state_q;
    logic [XLEN-1:0] cause_q;
    logic            status_mie, mtie, meie, mtip, meip, mtvec_mode;
    logic [XLEN-3:0] mtvec_base;
    logic [XLEN-1:0] mepc, vec_base_c, vec_off_c, trap_vec_c;
    logic            mret_fire_c, trap_commit_c, ext_pend_c, tmr_pend_c, take_c;

    assign mret_fire_c   = is_mret && (state_q == ST_IDLE);
    assign trap_commit_c = trap_ack && (state_q == ST_REQ);
    assign ext_pend_c    = meip && meie;
    assign tmr_pend_c    = mtip && mtie;
    // mret has priority; the new enable is evaluated on the following cycle.
    assign take_c        = status_mie && (ext_pend_c || tmr_pend_c) && !mret_fire_c;

    irq_csr_file #(
        .MTVEC_RESET (MTVEC_RESET)
    ) u_csr (
        .clk         (clk),
        .rst         (rst),
        .csr_we      (csr_we),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_rdata_c (csr_rdata),
        .timer_irq   (timer_irq),
        .ext_irq     (ext_irq),
        .trap_commit (trap_commit_c),
        .trap_cause  (cause_q),
        .instr_pc    (instr_pc),
        .mret_commit (mret_fire_c),
        .status_mie  (status_mie),
        .mtie        (mtie),
        .meie        (meie),
        .mtip        (mtip),
        .meip        (meip),
        .mtvec_base  (mtvec_base),
        .mtvec_mode  (mtvec_mode),
        .mepc        (mepc)
    );

    // Request is held with a frozen cause until the core acknowledges it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            trap_req <= 1'b0;
            cause_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (take_c) begin
                        state_q  <= ST_REQ;
                        trap_req <= 1'b1;
                        cause_q  <= ext_pend_c ? CAUSE_EXT : CAUSE_TIMER;
                    end
                end
                ST_REQ: begin
                    if (trap_ack) begin
                        state_q  <= ST_IDLE;
                        trap_req <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    trap_req <= 1'b0;
                end
            endcase
        end
    end

    assign vec_base_c = {mtvec_base, 2'b00};
    assign vec_off_c  = {25'b0, cause_q[4:0], 2'b00};
    assign trap_vec_c = mtvec_mode ? XLEN'(vec_base_c + vec_off_c) : vec_base_c;

    assign redirect = mret_fire_c;
    assign trap_pc  = (state_q == ST_REQ) ? trap_vec_c : mepc;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: CSR reset/masking, direct and vectored traps,
// priority, mret restore, same-cycle collisions and asynchronous reset.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        timer_irq, ext_irq, csr_we, is_mret, trap_ack;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, instr_pc;
    logic [31:0] csr_rdata, trap_pc;
    logic        trap_req, redirect;

    int checks = 0;
    int errors = 0;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MIP     = 12'h344;

    irq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .timer_irq (timer_irq),
        .ext_irq   (ext_irq),
        .csr_we    (csr_we),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .csr_rdata (csr_rdata),
        .instr_pc  (instr_pc),
        .is_mret   (is_mret),
        .trap_req  (trap_req),
        .trap_ack  (trap_ack),
        .redirect  (redirect),
        .trap_pc   (trap_pc)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        check(tag, csr_rdata, exp);
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        csr_we    = 1'b1;
        csr_addr  = a;
        csr_wdata = d;
        tick();
        csr_we    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; timer_irq = 1'b0; ext_irq = 1'b0; csr_we = 1'b0;
        is_mret = 1'b0; trap_ack = 1'b0; csr_addr = '0; csr_wdata = '0; instr_pc = '0;
        tick(); tick();
        rst = 1'b1;
        tick();

        // Reset state
        chk_csr("rst_mstatus", A_MSTATUS, 32'h0);
        chk_csr("rst_mie",     A_MIE,     32'h0);
        chk_csr("rst_mtvec",   A_MTVEC,   32'h0);
        chk_csr("rst_mepc",    A_MEPC,    32'h0);
        chk_csr("rst_mcause",  A_MCAUSE,  32'h0);
        chk_csr("rst_mip",     A_MIP,     32'h0);
        check("rst_trap_req", 32'(trap_req), 32'h0);
        check("rst_redirect", 32'(redirect), 32'h0);
        check("rst_trap_pc",  trap_pc,       32'h0);

        // Direct-mode timer trap
        csr_wr(A_MTVEC, 32'h100);
        csr_wr(A_MIE, 32'h80);
        csr_wr(A_MSTATUS, 32'h8);
        timer_irq = 1'b1;
        tick();
        timer_irq = 1'b0;
        check("dir_req_n1", 32'(trap_req), 32'h0);
        chk_csr("dir_mip_set", A_MIP, 32'h80);
        tick();
        check("dir_req_n2", 32'(trap_req), 32'h1);
        check("dir_trap_pc", trap_pc, 32'h100);
        is_mret = 1'b1;
        #1;
        check("req_mret_redirect", 32'(redirect), 32'h0);
        tick();
        is_mret = 1'b0;
        chk_csr("req_mret_ignored", A_MSTATUS, 32'h8);
        csr_wr(A_MIE, 32'h0);
        check("dir_req_held", 32'(trap_req), 32'h1);
        check("dir_pc_held", trap_pc, 32'h100);
        csr_wr(A_MIE, 32'h80);
        instr_pc = 32'h2040;
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
        check("dir_ack_req", 32'(trap_req), 32'h0);
        chk_csr("dir_mepc",    A_MEPC,    32'h2040);
        chk_csr("dir_mcause",  A_MCAUSE,  32'h8000_0007);
        chk_csr("dir_mstatus", A_MSTATUS, 32'h80);
        chk_csr("dir_mip",     A_MIP,     32'h0);

        // Vectored mode, external beats timer
        csr_wr(A_MTVEC, 32'h203);
        chk_csr("vec_mtvec_mask", A_MTVEC, 32'h201);
        csr_wr(A_MIE, 32'h880);
        csr_wr(A_MSTATUS, 32'h8);
        ext_irq = 1'b1;
        timer_irq = 1'b1;
        tick();
        timer_irq = 1'b0;
        check("pri_req", 32'(trap_req), 32'h1);
        check("pri_trap_pc", trap_pc, 32'h22C);
        instr_pc = 32'h3003;
        trap_ack = 1'b1;
        ext_irq = 1'b0;
        tick();
        trap_ack = 1'b0;
        chk_csr("pri_mcause",  A_MCAUSE,  32'h8000_000B);
        chk_csr("pri_mip",     A_MIP,     32'h80);
        chk_csr("pri_mepc",    A_MEPC,    32'h3000);
        chk_csr("pri_mstatus", A_MSTATUS, 32'h80);

        // mret restores enables; pending timer re-requests
        is_mret = 1'b1;
        #1;
        check("mret_redirect", 32'(redirect), 32'h1);
        check("mret_trap_pc", trap_pc, 32'h3000);
        tick();
        is_mret = 1'b0;
        chk_csr("mret_mstatus", A_MSTATUS, 32'h88);
        check("mret_no_req_yet", 32'(trap_req), 32'h0);
        tick();
        check("mret_rereq", 32'(trap_req), 32'h1);
        check("mret_vec_timer", trap_pc, 32'h21C);

        // Timer pulse on the cycle its own trap is acknowledged
        instr_pc = 32'h4000;
        timer_irq = 1'b1;
        trap_ack = 1'b1;
        tick();
        timer_irq = 1'b0;
        trap_ack = 1'b0;
        chk_csr("coll_mip",     A_MIP,     32'h80);
        chk_csr("coll_mcause",  A_MCAUSE,  32'h8000_0007);
        chk_csr("coll_mstatus", A_MSTATUS, 32'h80);
        chk_csr("coll_mepc",    A_MEPC,    32'h4000);
        check("coll_req", 32'(trap_req), 32'h0);

        // Masking with MIE = 0
        tick();
        check("mask_req0", 32'(trap_req), 32'h0);
        csr_wr(A_MIP, 32'h0);
        chk_csr("mask_mip_clr", A_MIP, 32'h0);
        timer_irq = 1'b1;
        tick();
        timer_irq = 1'b0;
        chk_csr("mask_mip_set", A_MIP, 32'h80);
        tick(); tick();
        check("mask_req1", 32'(trap_req), 32'h0);
        csr_wr(A_MIP, 32'h0);
        chk_csr("mask_mip_clr2", A_MIP, 32'h0);

        // Unmapped address
        csr_wr(12'h7C0, 32'hFFFF_FFFF);
        chk_csr("unmapped_rd", 12'h7C0, 32'h0);
        chk_csr("unmapped_side", A_MSTATUS, 32'h80);

        // mret coinciding with a pending interrupt: mret wins
        csr_wr(A_MSTATUS, 32'h8);
        csr_wr(A_MIP, 32'h80);
        is_mret = 1'b1;
        #1;
        check("mret_win_redirect", 32'(redirect), 32'h1);
        tick();
        is_mret = 1'b0;
        check("mret_win_req0", 32'(trap_req), 32'h0);
        chk_csr("mret_win_mstatus", A_MSTATUS, 32'h80);
        tick();
        check("mret_win_req1", 32'(trap_req), 32'h0);

        // Asynchronous reset while requesting
        csr_wr(A_MSTATUS, 32'h8);
        tick();
        check("arst_pre_req", 32'(trap_req), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_req", 32'(trap_req), 32'h0);
        chk_csr("arst_mip", A_MIP, 32'h0);
        chk_csr("arst_mstatus", A_MSTATUS, 32'h0);
        chk_csr("arst_mtvec", A_MTVEC, 32'h0);
        rst = 1'b1;
        tick();
        check("arst_post_req", 32'(trap_req), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
